// File: rtl/seq_store.sv
// Sequence store: append-only element buffer with handshaked playback
// and a registered random-read port.
module seq_store #(
    parameter int unsigned WIDTH = 3,
    parameter int unsigned DEPTH = 16,
    localparam int unsigned AW   = $clog2(DEPTH),
    localparam int unsigned LW   = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             push_err,
    input  logic             play_start,
    output logic             play_valid,
    input  logic             play_ready,
    output logic [WIDTH-1:0] play_data,
    output logic             play_last,
    input  logic [AW-1:0]    rd_idx,
    output logic [WIDTH-1:0] rd_data,
    output logic [LW-1:0]    len,
    output logic             full,
    output logic             empty
);

    typedef enum logic {
        IDLE = 1'b0,
        PLAY = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    idx_q, idx_d;
    logic [LW-1:0]    len_q, len_d;
    logic             push_err_q, push_err_d;
    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic             mem_we;
    logic [WIDTH-1:0] mem_q [DEPTH];

    assign full       = (len_q == LW'(DEPTH));
    assign empty      = (len_q == '0);
    assign len        = len_q;
    assign push_err   = push_err_q;
    assign rd_data    = rd_data_q;
    assign play_valid = (state_q == PLAY);
    assign play_data  = (state_q == PLAY) ? mem_q[idx_q] : '0;
    assign play_last  = (state_q == PLAY) && (LW'(idx_q) == (len_q - LW'(1)));

    // Next-state: clear overrides everything; push and play_start may share a
    // cycle in IDLE, in which case playback covers the freshly appended element.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        len_d      = len_q;
        push_err_d = 1'b0;
        mem_we     = 1'b0;
        rd_data_d  = (LW'(rd_idx) < len_q) ? mem_q[rd_idx] : '0;
        if (clear) begin
            state_d = IDLE;
            idx_d   = '0;
            len_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (push) begin
                        if (full) begin
                            push_err_d = 1'b1;
                        end else begin
                            mem_we = 1'b1;
                            len_d  = len_q + LW'(1);
                        end
                    end
                    if (play_start && (len_d != '0)) begin
                        state_d = PLAY;
                        idx_d   = '0;
                    end
                end
                PLAY: begin
                    push_err_d = push;
                    if (play_ready) begin
                        if (play_last) begin
                            state_d = IDLE;
                            idx_d   = '0;
                        end else begin
                            idx_d = idx_q + AW'(1);
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    idx_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            len_q      <= '0;
            push_err_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            len_q      <= len_d;
            push_err_q <= push_err_d;
            rd_data_q  <= rd_data_d;
        end
    end

    // Element storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (!rst && mem_we) begin
            mem_q[len_q[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: tb/tb_seq_store.sv
// Directed bench for seq_store: playback elements are checked by a
// queue-driven monitor, status outputs by inline checks.
module tb_seq_store;

    localparam int unsigned WIDTH = 3;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned AW    = 4;
    localparam int unsigned LW    = 5;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             last;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst, clear, push, play_start, play_ready;
    logic [WIDTH-1:0] push_data;
    logic [AW-1:0]    rd_idx;
    logic             push_err, play_valid, play_last, full, empty;
    logic [WIDTH-1:0] play_data, rd_data;
    logic [LW-1:0]    len;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_hs  = 0;

    seq_store #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .push       (push),
        .push_data  (push_data),
        .push_err   (push_err),
        .play_start (play_start),
        .play_valid (play_valid),
        .play_ready (play_ready),
        .play_data  (play_data),
        .play_last  (play_last),
        .rd_idx     (rd_idx),
        .rd_data    (rd_data),
        .len        (len),
        .full       (full),
        .empty      (empty)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic do_push(input logic [WIDTH-1:0] v);
        push      = 1'b1;
        push_data = v;
        tick();
        push      = 1'b0;
    endtask

    task automatic expect_elem(input logic [WIDTH-1:0] d, input logic l);
        exp_t e;
        e.data = d;
        e.last = l;
        exp_q.push_back(e);
    endtask

    // Monitor: every accepted playback element must match the next expected one.
    always @(negedge clk) begin
        if (play_valid && play_ready) begin
            n_hs++;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL play_extra: got data %0d last %0d expected no element", play_data, play_last);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (play_data !== e.data || play_last !== e.last) begin
                    n_err++;
                    $display("FAIL play_elem: got data %0d last %0d expected data %0d last %0d",
                             play_data, play_last, e.data, e.last);
                end
            end
        end
    end

    initial begin
        int hs0;
        rst = 1'b1; clear = 1'b0; push = 1'b0; play_start = 1'b0; play_ready = 1'b0;
        push_data = '0; rd_idx = '0;
        tick();
        tick();
        check("rst_len", 32'(len), 0);
        check("rst_empty", 32'(empty), 1);
        check("rst_full", 32'(full), 0);
        check("rst_valid", 32'(play_valid), 0);
        check("rst_last", 32'(play_last), 0);
        check("rst_pdata", 32'(play_data), 0);
        check("rst_err", 32'(push_err), 0);
        check("rst_rdata", 32'(rd_data), 0);
        rst = 1'b0;

        // push 5,2,7 and play with ready held high
        do_push(3'd5); do_push(3'd2); do_push(3'd7);
        check("len3", 32'(len), 3);
        expect_elem(3'd5, 1'b0); expect_elem(3'd2, 1'b0); expect_elem(3'd7, 1'b1);
        hs0 = n_hs;
        play_ready = 1'b1; play_start = 1'b1;
        tick();
        play_start = 1'b0;
        check("p1_valid0", 32'(play_valid), 1);
        tick();
        check("p1_valid1", 32'(play_valid), 1);
        tick();
        check("p1_valid2", 32'(play_valid), 1);
        check("p1_last2", 32'(play_last), 1);
        tick();
        check("p1_done", 32'(play_valid), 0);
        check("p1_hs", 32'(n_hs - hs0), 3);

        // random read
        rd_idx = 4'd2; tick();
        check("rd_idx2", 32'(rd_data), 7);
        rd_idx = 4'd5; tick();
        check("rd_idx5", 32'(rd_data), 0);

        // push during PLAY, then stall at idx 1
        expect_elem(3'd5, 1'b0); expect_elem(3'd2, 1'b0); expect_elem(3'd7, 1'b1);
        play_ready = 1'b0; play_start = 1'b1;
        tick();
        play_start = 1'b0;
        do_push(3'd3);
        check("play_push_err", 32'(push_err), 1);
        check("play_push_len", 32'(len), 3);
        tick();
        check("play_push_err_clr", 32'(push_err), 0);
        play_ready = 1'b1;
        tick();
        play_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_data", 32'(play_data), 2);
            check("stall_last", 32'(play_last), 0);
            check("stall_valid", 32'(play_valid), 1);
        end
        play_ready = 1'b1;
        tick(); tick(); tick();
        check("p2_done", 32'(play_valid), 0);

        // clear mid-playback at idx 1
        expect_elem(3'd5, 1'b0);
        play_ready = 1'b0; play_start = 1'b1;
        tick();
        play_start = 1'b0; play_ready = 1'b1;
        tick();
        play_ready = 1'b0; clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clr_valid", 32'(play_valid), 0);
        check("clr_len", 32'(len), 0);
        check("clr_empty", 32'(empty), 1);
        play_start = 1'b1;
        tick();
        play_start = 1'b0;
        check("clr_start_ign", 32'(play_valid), 0);

        // fill to DEPTH, then overflow
        for (int i = 0; i < 16; i++) do_push(3'((i * 3) % 8));
        check("fill_full", 32'(full), 1);
        check("fill_len", 32'(len), 16);
        do_push(3'd6);
        check("ovf_err", 32'(push_err), 1);
        check("ovf_len", 32'(len), 16);
        rd_idx = 4'd15; tick();
        check("ovf_err_clr", 32'(push_err), 0);
        check("ovf_mem15", 32'(rd_data), 5);
        rd_idx = 4'd0; tick();
        check("ovf_mem0", 32'(rd_data), 0);

        // reset during playback
        play_ready = 1'b0; play_start = 1'b1;
        tick();
        play_start = 1'b0;
        check("pre_rst_valid", 32'(play_valid), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mrst_valid", 32'(play_valid), 0);
        check("mrst_last", 32'(play_last), 0);
        check("mrst_pdata", 32'(play_data), 0);
        check("mrst_err", 32'(push_err), 0);
        check("mrst_empty", 32'(empty), 1);
        check("mrst_full", 32'(full), 0);
        check("mrst_len", 32'(len), 0);
        check("mrst_rdata", 32'(rd_data), 0);

        // single element playback
        do_push(3'd1);
        check("single_len", 32'(len), 1);
        expect_elem(3'd1, 1'b1);
        play_ready = 1'b1; play_start = 1'b1;
        tick();
        play_start = 1'b0;
        check("single_last", 32'(play_last), 1);
        tick();
        check("single_done", 32'(play_valid), 0);

        // push and play_start together: playback includes the new element
        expect_elem(3'd1, 1'b0); expect_elem(3'd3, 1'b1);
        push = 1'b1; push_data = 3'd3; play_start = 1'b1;
        tick();
        push = 1'b0; play_start = 1'b0;
        check("pp_len", 32'(len), 2);
        check("pp_valid", 32'(play_valid), 1);
        tick();
        tick();
        check("pp_done", 32'(play_valid), 0);

        tick();
        check("queue_drained", 32'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
